// File: rtl/glb_bank_responder_pkg.sv
// glb_bank_responder_pkg: GLB address geometry, bank packet types and read latency.
// glb_bank_rd_latency depends on GLB_BANK_RD_OUT_REG_EN.
package glb_bank_responder_pkg;
  localparam int BANK_DATA_WIDTH = 64;
  localparam int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8;
  localparam int BANK_ADDR_WIDTH = 17;
  localparam int BANK_ADDR_BYTE_OFFSET = 3;
  localparam int BANK_WORD_ADDR_WIDTH = BANK_ADDR_WIDTH - BANK_ADDR_BYTE_OFFSET;
  localparam int BANK_DEPTH = 1 << BANK_WORD_ADDR_WIDTH;
  localparam int BANKS_PER_TILE = 2;
  localparam int BANK_SEL_ADDR_WIDTH = $clog2(BANKS_PER_TILE);
  localparam int NUM_GLB_TILES = 16;
  localparam int TILE_SEL_ADDR_WIDTH = $clog2(NUM_GLB_TILES);
  localparam int GLB_ADDR_WIDTH = BANK_ADDR_WIDTH + BANK_SEL_ADDR_WIDTH + TILE_SEL_ADDR_WIDTH;
  localparam int RDRQ_QUEUE_DEPTH = 2;
`ifdef GLB_BANK_RD_OUT_REG_EN
  localparam int glb_bank_rd_latency = 2;
`else
  localparam int glb_bank_rd_latency = 1;
`endif
  typedef logic [BANK_WORD_ADDR_WIDTH-1:0] bank_waddr_t;
  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;
  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;
  typedef struct packed {
    logic [BANK_DATA_WIDTH-1:0] rd_data;
    logic                       rd_data_valid;
  } rdrs_packet_t;
endpackage

// File: rtl/glb_bank_responder_if.sv
// glb_bank_responder_if: router-to-bank packet bundle; master is the router, slave the bank.
interface glb_bank_responder_if;
  import glb_bank_responder_pkg::*;
  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id;
  wr_packet_t   wr_packet;
  rdrq_packet_t rdrq_packet;
  rdrs_packet_t rdrs_packet;
  logic         rdrq_drop;
  modport master (output glb_tile_id, wr_packet, rdrq_packet, input rdrs_packet, rdrq_drop);
  modport slave (input glb_tile_id, wr_packet, rdrq_packet, output rdrs_packet, rdrq_drop);
endinterface

// File: rtl/glb_bank_sram.sv
// glb_bank_sram: behavioural single-port 64x16384 SRAM, byte write enables, registered read, no reset.
module glb_bank_sram
  import glb_bank_responder_pkg::*;
(
  input  logic                       clk,
  input  logic                       cen,
  input  logic                       wen,
  input  bank_waddr_t                addr,
  input  logic [BANK_STRB_WIDTH-1:0] wstrb,
  input  logic [BANK_DATA_WIDTH-1:0] wdata,
  output logic [BANK_DATA_WIDTH-1:0] rdata
);
  logic [BANK_DATA_WIDTH-1:0] mem [BANK_DEPTH];
  always_ff @(posedge clk) begin
    if (cen && wen)
      for (int i = 0; i < BANK_STRB_WIDTH; i++)
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (cen && !wen) rdata <= mem[addr];
  end
endmodule

// File: rtl/glb_bank_responder.sv
// glb_bank_responder: bank-side write/read-request servicing with a 2-entry pending-read queue.
// GLB_BANK_RD_OUT_REG_EN adds an output register (read latency 2 instead of 1).
module glb_bank_responder
  import glb_bank_responder_pkg::*;
#(
  parameter int BANK_ID = 0
) (
  input logic clk,
  input logic reset_n,
  glb_bank_responder_if.slave bif
);
  localparam logic [BANK_SEL_ADDR_WIDTH-1:0] BANK_SEL = BANK_SEL_ADDR_WIDTH'(BANK_ID);
  localparam int CNT_W = $clog2(RDRQ_QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RDRQ_QUEUE_DEPTH);
  logic wr_hit, rd_hit, pop, push, rd_issue, drop;
  bank_waddr_t wr_waddr, rd_waddr, sram_addr;
  bank_waddr_t q_q [RDRQ_QUEUE_DEPTH];
  bank_waddr_t q_d [RDRQ_QUEUE_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_pop;
  logic sram_vld_q, sram_vld_d;
  logic [BANK_DATA_WIDTH-1:0] sram_rdata, data_q, data_d;
  always_comb begin
    wr_hit = reset_n && bif.wr_packet.wr_en && |bif.wr_packet.wr_strb &&
             bif.wr_packet.wr_addr[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH] == {bif.glb_tile_id, BANK_SEL};
    rd_hit = reset_n && bif.rdrq_packet.rd_en &&
             bif.rdrq_packet.rd_addr[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH] == {bif.glb_tile_id, BANK_SEL};
    wr_waddr = bif.wr_packet.wr_addr[BANK_ADDR_WIDTH-1:BANK_ADDR_BYTE_OFFSET];
    rd_waddr = bif.rdrq_packet.rd_addr[BANK_ADDR_WIDTH-1:BANK_ADDR_BYTE_OFFSET];
    pop = reset_n && !wr_hit && cnt_q != '0;
    rd_issue = reset_n && !wr_hit && (cnt_q != '0 || rd_hit);
    // incoming read waits unless it goes straight to an idle port; dropped only when full and blocked
    push = rd_hit && !(wr_hit ? cnt_q == FULL : cnt_q == '0);
    drop = rd_hit && wr_hit && cnt_q == FULL;
    sram_addr = wr_hit ? wr_waddr : pop ? q_q[0] : rd_waddr;
    cnt_pop = cnt_q - CNT_W'(pop);
    cnt_d = cnt_pop + CNT_W'(push);
    q_d = q_q;
    if (pop) q_d[0] = q_q[1];
    if (push) q_d[cnt_pop[0]] = rd_waddr;
    sram_vld_d = rd_issue;
    data_d = sram_vld_q ? sram_rdata : data_q;
  end
  glb_bank_sram u_sram (
    .clk   (clk),
    .cen   (wr_hit || rd_issue),
    .wen   (wr_hit),
    .addr  (sram_addr),
    .wstrb (bif.wr_packet.wr_strb),
    .wdata (bif.wr_packet.wr_data),
    .rdata (sram_rdata)
  );
`ifdef GLB_BANK_RD_OUT_REG_EN
  logic vld_q;
  always_ff @(posedge clk) begin
    if (!reset_n) vld_q <= 1'b0;
    else vld_q <= sram_vld_q;
  end
  always_comb bif.rdrs_packet = '{rd_data: data_q, rd_data_valid: vld_q};
`else
  // reset_n gating keeps a read issued just before reset from surfacing during the reset cycle
  always_comb bif.rdrs_packet = '{rd_data: (sram_vld_q && reset_n) ? sram_rdata : data_q,
                                  rd_data_valid: sram_vld_q && reset_n};
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sram_vld_q <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sram_vld_q <= sram_vld_d;
      data_q <= data_d;
    end
    q_q <= q_d;
  end
  assign bif.rdrq_drop = drop;
endmodule
